// File: rtl/inst_fetch_queue_pkg.sv
// rtl/inst_fetch_queue_pkg.sv - shared widths, opcodes and FSM encoding for the instruction fetch queue
package inst_fetch_queue_pkg;

    localparam int INST_LEN = 220;
    localparam int IN_W     = 64;
    localparam int BEATS    = (INST_LEN + IN_W - 1) / IN_W;
    localparam int DEPTH    = 16;
    localparam int PTR_W    = $clog2(DEPTH);
    localparam int PROG_W   = 16;
    localparam int BEAT_W   = $clog2(BEATS);
    // Beats 0..BEATS-2 are held in the assembly register; the last beat is merged on the fly.
    localparam int ASM_W    = (BEATS - 1) * IN_W;
    localparam int LAST_W   = INST_LEN - ASM_W;

    localparam logic [3:0] OP_COMPUTE   = 4'd0;
    localparam logic [3:0] OP_LD_WEIGHT = 4'd1;
    localparam logic [3:0] OP_LD_BIAS   = 4'd2;
    localparam logic [3:0] OP_LD_DATA   = 4'd3;
    localparam logic [3:0] OP_WR_DATA   = 4'd4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    function automatic logic [3:0] opcode_of(input logic [INST_LEN-1:0] inst);
        return inst[3:0];
    endfunction

endpackage

// File: rtl/inst_fetch_queue_if.sv
// rtl/inst_fetch_queue_if.sv - host beat stream, controller pop port and run status of the fetch queue
interface inst_fetch_queue_if;
    import inst_fetch_queue_pkg::*;

    logic                start;
    logic [PROG_W-1:0]   prog_len;
    logic                in_valid;
    logic                in_ready;
    logic [IN_W-1:0]     in_data;
    logic [INST_LEN-1:0] instruct;
    logic                inst_empty;
    logic                inst_req;
    logic [PTR_W:0]      fill_level;
    logic [PROG_W-1:0]   issued_cnt;
    logic                busy;
    logic                done;

    modport master (
        output start, prog_len, in_valid, in_data, inst_req,
        input  in_ready, instruct, inst_empty, fill_level, issued_cnt, busy, done
    );

    modport slave (
        input  start, prog_len, in_valid, in_data, inst_req,
        output in_ready, instruct, inst_empty, fill_level, issued_cnt, busy, done
    );

endinterface

// File: rtl/inst_fwft_fifo.sv
// rtl/inst_fwft_fifo.sv - show-ahead FIFO; the head word sits on rd_data_o whenever the queue is non-empty
module inst_fwft_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 16,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [PTR_W:0]   count_o
);

    localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             do_push;
    logic             do_pop;

    // Both guards use registered state, so a pop never makes room for a same-cycle push.
    assign full_o    = (count_q == FULL_CNT);
    assign empty_o   = (count_q == '0);
    assign count_o   = count_q;
    assign do_push   = push_i && !full_o;
    assign do_pop    = pop_i && !empty_o;
    assign rd_data_o = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is cleared on reset so the show-ahead head reads as zero afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/inst_fetch_queue.sv
// rtl/inst_fetch_queue.sv - assembles host beats into instructions and queues them for the controller
module inst_fetch_queue
    import inst_fetch_queue_pkg::*;
(
    input logic               clk,
    input logic               rst_n,
    inst_fetch_queue_if.slave bus
);

    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
    localparam logic [BEAT_W-1:0] BEAT_ONE  = BEAT_W'(1);
    localparam logic [PROG_W-1:0] PROG_ONE  = PROG_W'(1);

    state_e              state_q, state_d;
    logic [PROG_W-1:0]   prog_len_q, prog_len_d;
    logic [PROG_W-1:0]   recv_cnt_q, recv_cnt_d;
    logic [PROG_W-1:0]   issued_cnt_q, issued_cnt_d;
    logic [BEAT_W-1:0]   beat_cnt_q, beat_cnt_d;
    logic [ASM_W-1:0]    asm_q, asm_d;
    logic                done_q, done_d;

    logic                fifo_full;
    logic                fifo_empty;
    logic [PTR_W:0]      fifo_count;
    logic [INST_LEN-1:0] fifo_head;
    logic [INST_LEN-1:0] push_data;
    logic                last_beat;
    logic                beat_acc;
    logic                push;
    logic                pop;

    assign last_beat    = (beat_cnt_q == LAST_BEAT);
    assign bus.in_ready = (state_q == ST_RUN) && (!last_beat || !fifo_full);
    assign beat_acc     = bus.in_valid && bus.in_ready;
    assign push         = beat_acc && last_beat;
    assign pop          = bus.inst_req && !fifo_empty;
    // Bits of the last beat beyond INST_LEN are dropped here.
    assign push_data    = {bus.in_data[LAST_W-1:0], asm_q};

    assign bus.instruct   = fifo_head;
    assign bus.inst_empty = fifo_empty;
    assign bus.fill_level = fifo_count;
    assign bus.issued_cnt = issued_cnt_q;
    assign bus.busy       = (state_q != ST_IDLE);
    assign bus.done       = done_q;

    inst_fwft_fifo #(
        .WIDTH (INST_LEN),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (push),
        .push_data_i (push_data),
        .pop_i       (pop),
        .rd_data_o   (fifo_head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count)
    );

    always_comb begin
        asm_d = asm_q;
        for (int k = 0; k < BEATS - 1; k++) begin
            if (beat_acc && (beat_cnt_q == BEAT_W'(k))) begin
                asm_d[k*IN_W +: IN_W] = bus.in_data;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        prog_len_d   = prog_len_q;
        recv_cnt_d   = recv_cnt_q;
        issued_cnt_d = issued_cnt_q;
        beat_cnt_d   = beat_cnt_q;
        done_d       = 1'b0;

        if (beat_acc) begin
            beat_cnt_d = last_beat ? '0 : beat_cnt_q + BEAT_ONE;
        end
        if (push) begin
            recv_cnt_d = recv_cnt_q + PROG_ONE;
        end
        if (pop) begin
            issued_cnt_d = issued_cnt_q + PROG_ONE;
        end

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    prog_len_d   = bus.prog_len;
                    recv_cnt_d   = '0;
                    issued_cnt_d = '0;
                    beat_cnt_d   = '0;
                    if (bus.prog_len == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                // Leaving RUN on the final push keeps in_ready low for any surplus beats.
                if (push && (recv_cnt_d == prog_len_q)) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (issued_cnt_q == prog_len_q) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            prog_len_q   <= '0;
            recv_cnt_q   <= '0;
            issued_cnt_q <= '0;
            beat_cnt_q   <= '0;
            asm_q        <= '0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            prog_len_q   <= prog_len_d;
            recv_cnt_q   <= recv_cnt_d;
            issued_cnt_q <= issued_cnt_d;
            beat_cnt_q   <= beat_cnt_d;
            asm_q        <= asm_d;
            done_q       <= done_d;
        end
    end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// tb/tb_inst_fetch_queue.sv - randomized scoreboard bench for the instruction fetch queue
module tb_inst_fetch_queue;
    import inst_fetch_queue_pkg::*;

    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    int   req_mode = 0;
    int   prog_runs = 0;

    logic [INST_LEN-1:0] sb [$];
    logic [INST_LEN-1:0] first_inst;

    inst_fetch_queue_if bus ();

    inst_fetch_queue dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Controller-side pop pattern: 0 off, 1 every other cycle, 2 random, else every cycle.
    initial begin
        bus.inst_req = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (req_mode)
                0:       bus.inst_req = 1'b0;
                1:       bus.inst_req = !bus.inst_req;
                2:       bus.inst_req = 1'($urandom_range(0, 1));
                default: bus.inst_req = 1'b1;
            endcase
        end
    end

    // Reference model: run phase, instruction count in the queue, beat position in the
    // current instruction, received/issued totals. Checked every cycle on the falling edge.
    int m_phase = 0;
    int m_count = 0;
    int m_beat = 0;
    int m_recv = 0;
    int m_issued = 0;
    int m_len = 0;
    bit m_done = 1'b0;

    always @(negedge clk or negedge rst_n) begin
        bit pred_rdy, acc, push, pop, n_done;
        int iss_before;
        logic [INST_LEN-1:0] exp_inst;
        if (!rst_n) begin
            m_phase = 0; m_count = 0; m_beat = 0; m_recv = 0;
            m_issued = 0; m_len = 0; m_done = 1'b0;
        end else begin
            pred_rdy = (m_phase == 1) && (m_beat != BEATS - 1 || m_count < DEPTH);
            chk("fill_level", bus.fill_level, m_count);
            chk("inst_empty", bus.inst_empty, m_count == 0);
            chk("in_ready", bus.in_ready, pred_rdy);
            chk("issued_cnt", bus.issued_cnt, m_issued);
            chk("busy", bus.busy, m_phase != 0);
            chk("done", bus.done, m_done);

            pop = bus.inst_req && (m_count > 0);
            if (pop) begin
                chk("sb_has_entry", sb.size() > 0, 1);
                if (sb.size() > 0) begin
                    exp_inst = sb.pop_front();
                    chk("instruct", bus.instruct, exp_inst);
                end
            end

            acc  = bus.in_valid && pred_rdy;
            push = acc && (m_beat == BEATS - 1);
            iss_before = m_issued;
            n_done = 1'b0;
            if (acc) m_beat = (m_beat == BEATS - 1) ? 0 : m_beat + 1;
            m_count = m_count + int'(push) - int'(pop);
            if (pop) m_issued++;
            if (push) m_recv++;
            case (m_phase)
                0: if (bus.start) begin
                    m_len = int'(bus.prog_len);
                    m_recv = 0; m_issued = 0; m_beat = 0;
                    if (m_len == 0) n_done = 1'b1;
                    else m_phase = 1;
                end
                1: if (push && m_recv == m_len) m_phase = 2;
                default: if (iss_before == m_len) begin
                    n_done = 1'b1;
                    m_phase = 0;
                end
            endcase
            m_done = n_done;
        end
    end

    function automatic logic [3:0] pick_op();
        case ($urandom_range(0, 4))
            0:       return OP_COMPUTE;
            1:       return OP_LD_WEIGHT;
            2:       return OP_LD_BIAS;
            3:       return OP_LD_DATA;
            default: return OP_WR_DATA;
        endcase
    endfunction

    task automatic send_beat(input logic [IN_W-1:0] d, input bit gaps, input bit st, output bit ok);
        bit r;
        ok = 1'b0;
        if (gaps && $urandom_range(0, 2) == 0) begin
            bus.in_valid = 1'b0;
            repeat ($urandom_range(1, 2)) begin
                @(posedge clk);
                #1;
            end
        end
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        if (st) begin
            bus.start    = 1'b1;
            bus.prog_len = 16'd7;
        end
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            r = bus.in_ready;
            @(posedge clk);
            #1;
            bus.start = 1'b0;
            if (r) begin
                bus.in_valid = 1'b0;
                ok = 1'b1;
                return;
            end
        end
        bus.in_valid = 1'b0;
    endtask

    // Streams len random instructions; the unused top bits of the last beat carry junk.
    task automatic send_prog(input int len, input bit gaps, input int mid_start_at, input int stop_beats);
        logic [BEATS*IN_W-1:0] w;
        logic [INST_LEN-1:0]   inst;
        bit ok;
        int beats = 0;
        bus.start    = 1'b1;
        bus.prog_len = PROG_W'(len);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        for (int i = 0; i < len; i++) begin
            for (int j = 0; j < BEATS * IN_W / 32; j++) w[j*32 +: 32] = $urandom;
            w[3:0] = pick_op();
            inst = w[INST_LEN-1:0];
            sb.push_back(inst);
            if (i == 0) first_inst = inst;
            for (int k = 0; k < BEATS; k++) begin
                if (stop_beats >= 0 && beats == stop_beats) begin
                    prog_runs++;
                    return;
                end
                send_beat(w[k*IN_W +: IN_W], gaps, (i == mid_start_at) && (k == 0), ok);
                chk("beat_accepted", ok, 1);
                if (!ok) begin
                    prog_runs++;
                    return;
                end
                beats++;
            end
        end
        prog_runs++;
    endtask

    task automatic wait_idle(input string nm);
        int n = 0;
        @(negedge clk);
        while (bus.busy && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk(nm, n < 3000, 1);
        repeat (2) @(negedge clk);
        chk({nm, "_sb_empty"}, sb.size(), 0);
    endtask

    task automatic check_reset_vals(input string nm);
        chk({nm, "_in_ready"}, bus.in_ready, 0);
        chk({nm, "_inst_empty"}, bus.inst_empty, 1);
        chk({nm, "_instruct"}, bus.instruct, 0);
        chk({nm, "_fill_level"}, bus.fill_level, 0);
        chk({nm, "_issued_cnt"}, bus.issued_cnt, 0);
        chk({nm, "_busy"}, bus.busy, 0);
        chk({nm, "_done"}, bus.done, 0);
    endtask

    initial begin
        int n, stall, runs0;
        bus.start    = 1'b0;
        bus.prog_len = '0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        rst_n        = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("rst_init");
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Three instructions streamed with no pops, then drained.
        send_prog(3, 1'b0, -1, -1);
        repeat (2) @(negedge clk);
        chk("t1_fill", bus.fill_level, 3);
        chk("t1_head", bus.instruct, first_inst);
        chk("t1_opcode", opcode_of(bus.instruct), first_inst[3:0]);
        req_mode = 1;
        wait_idle("t1_idle");
        req_mode = 0;

        // Fill the queue to DEPTH, observe the stall, release it with one pop.
        runs0 = prog_runs;
        stall = 0;
        n = 0;
        fork
            send_prog(17, 1'b0, -1, -1);
        join_none
        while (stall < 3 && n < 2000) begin
            @(negedge clk);
            if (bus.in_valid && !bus.in_ready && bus.fill_level == 5'd16) stall++;
            n++;
        end
        chk("t2_stall_seen", stall, 3);
        req_mode = 3;
        @(negedge clk);
        req_mode = 0;
        n = 0;
        while (prog_runs == runs0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("t2_driver_done", prog_runs != runs0, 1);
        chk("t2_fill_after", bus.fill_level, 16);
        req_mode = 1;
        wait_idle("t2_idle");
        req_mode = 0;

        // Controller-style alternate pops while streaming back to back.
        req_mode = 1;
        send_prog(20, 1'b0, -1, -1);
        wait_idle("t3_idle");

        // Random pops and input gaps; a start mid-run must be ignored.
        req_mode = 2;
        send_prog(40, 1'b1, 3, -1);
        wait_idle("t4_idle");

        // Pops while empty leave counters alone.
        req_mode = 2;
        repeat (12) @(negedge clk);
        req_mode = 0;
        chk("t5_issued", bus.issued_cnt, 40);
        chk("t5_fill", bus.fill_level, 0);

        // Zero-length program.
        @(posedge clk);
        #1;
        send_prog(0, 1'b0, -1, -1);
        repeat (3) @(negedge clk);
        chk("t6_busy", bus.busy, 0);
        chk("t6_issued", bus.issued_cnt, 0);

        // Asynchronous reset with five queued and a partial instruction (beat_cnt=2).
        send_prog(10, 1'b0, -1, 22);
        @(negedge clk);
        chk("t7_fill_pre", bus.fill_level, 5);
        chk("t7_busy_pre", bus.busy, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_vals("rst_mid");
        sb.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        req_mode = 1;
        send_prog(4, 1'b1, -1, -1);
        wait_idle("t7_idle");
        req_mode = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
